// File: rtl/la_footer_seq.sv
// Power-gating sequencer for a footer-switched ground domain: orders isolation,
// retention and segment enables on sleep, and staggers segment turn-on on wake.
module la_footer_seq #(
  parameter int N    = 4,
  parameter int STEP = 8,
  parameter int HOLD = 2,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         sleep_req,
  output logic         sleep_ack,
  output logic         busy,
  output logic [N-1:0] nsleep,
  output logic         iso,
  output logic         ret
);

  localparam int MaxPhase = (STEP > HOLD) ? STEP : HOLD;
  localparam int CW       = $clog2(MaxPhase + 1);
  localparam int IW       = $clog2(N + 1);

  localparam logic [CW-1:0] StepLoad = CW'(STEP - 1);
  localparam logic [CW-1:0] HoldLoad = CW'(HOLD - 1);
  localparam logic [IW-1:0] LastSeg  = IW'(N - 1);

  if (N < 1 || STEP < 1 || HOLD < 1 || $bits(PROP) == 0) begin : g_param_check
    $error("la_footer_seq: N, STEP and HOLD must all be at least 1");
  end

  typedef enum logic [2:0] {
    S_ON,
    S_ISO,
    S_RET,
    S_PDN,
    S_OFF,
    S_PUP,
    S_UNRET
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   nsleep_q, nsleep_d;
  logic           iso_q, iso_d;
  logic           ret_q, ret_d;
  logic           ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           phaseDone;

  // Every phase reloads the counter on entry and leaves once it reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    nsleep_d  = nsleep_q;
    phaseDone = (cnt_q == '0);
    if (phaseDone) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end

    case (state_q)
      S_ON: begin
        if (sleep_req) begin
          state_d = S_ISO;
          cnt_d   = HoldLoad;
        end
      end
      S_ISO: begin
        if (phaseDone) begin
          state_d = S_RET;
          cnt_d   = HoldLoad;
        end
      end
      S_RET: begin
        if (phaseDone) begin
          state_d  = S_PDN;
          cnt_d    = HoldLoad;
          nsleep_d = '0;
        end
      end
      S_PDN: begin
        if (phaseDone) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      end
      S_OFF: begin
        if (!sleep_req) begin
          state_d     = S_PUP;
          cnt_d       = StepLoad;
          idx_d       = '0;
          nsleep_d[0] = 1'b1;
        end
      end
      S_PUP: begin
        if (phaseDone) begin
          if (idx_q == LastSeg) begin
            state_d = S_UNRET;
            cnt_d   = HoldLoad;
          end else begin
            idx_d = idx_q + IW'(1);
            cnt_d = StepLoad;
            for (int k = 0; k < N; k++) begin
              if (idx_d == IW'(k)) begin
                nsleep_d[k] = 1'b1;
              end
            end
          end
        end
      end
      S_UNRET: begin
        // Dropping isolation coincides with re-entering ON.
        if (phaseDone) begin
          state_d = S_ON;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d  = S_ON;
        cnt_d    = '0;
        idx_d    = '0;
        nsleep_d = '1;
      end
    endcase

    iso_d  = (state_d != S_ON);
    ret_d  = (state_d == S_RET) || (state_d == S_PDN) ||
             (state_d == S_OFF) || (state_d == S_PUP);
    ack_d  = (state_d == S_OFF);
    busy_d = (state_d != S_ON) && (state_d != S_OFF);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_ON;
      cnt_q    <= '0;
      idx_q    <= '0;
      nsleep_q <= '1;
      iso_q    <= 1'b0;
      ret_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      nsleep_q <= nsleep_d;
      iso_q    <= iso_d;
      ret_q    <= ret_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign nsleep    = nsleep_q;
  assign iso       = iso_q;
  assign ret       = ret_q;
  assign sleep_ack = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_la_footer_seq.sv
// Directed bench for la_footer_seq: sleep/wake timing, ignored requests,
// async reset mid-wake, and invariant monitoring on N=1 / N=8 variants.
module tb_la_footer_seq;

  logic       clk;
  logic       nreset;
  logic       sleepReq;
  logic       sleepAck;
  logic       busy;
  logic [3:0] nsleep;
  logic       iso;
  logic       ret;

  logic       req1, ack1, busy1, iso1, ret1;
  logic [0:0] ns1;
  logic       req8, ack8, busy8, iso8, ret8;
  logic [7:0] ns8;

  int testsRun;
  int testsFailed;

  la_footer_seq #(.N(4), .STEP(8), .HOLD(2), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset), .sleep_req(sleepReq), .sleep_ack(sleepAck),
    .busy(busy), .nsleep(nsleep), .iso(iso), .ret(ret)
  );

  la_footer_seq #(.N(1), .STEP(1), .HOLD(1), .PROP("N1")) dut1 (
    .clk(clk), .nreset(nreset), .sleep_req(req1), .sleep_ack(ack1),
    .busy(busy1), .nsleep(ns1), .iso(iso1), .ret(ret1)
  );

  la_footer_seq #(.N(8), .STEP(1), .HOLD(1), .PROP("N8")) dut8 (
    .clk(clk), .nreset(nreset), .sleep_req(req8), .sleep_ack(ack8),
    .busy(busy8), .nsleep(ns8), .iso(iso8), .ret(ret8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {nsleep, iso, ret, sleep_ack, busy} at cycle T+m of a power-down.
  function automatic logic [7:0] expectDown(input int m);
    logic [3:0] ns;
    ns = (m >= 5) ? 4'b0000 : 4'b1111;
    return {ns, 1'b1, (m >= 3), (m >= 7), (m <= 6)};
  endfunction

  // Expected {nsleep, iso, ret, sleep_ack, busy} at cycle T+m of a power-up.
  function automatic logic [7:0] expectUp(input int m);
    logic [3:0] ns;
    ns = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (m >= 1 + k * 8) ns[k] = 1'b1;
    end
    return {ns, (m < 35), (m < 33), 1'b0, (m < 35)};
  endfunction

  task automatic test_reset();
    logic [7:0] obs;
    nreset   = 1'b0;
    sleepReq = 1'b0;
    req1     = 1'b0;
    req8     = 1'b0;
    #12;
    obs = {nsleep, iso, ret, sleepAck, busy};
    testsRun++;
    if (obs !== 8'b1111_0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_asserted: got %b expected %b", obs, 8'b1111_0000);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      obs = {nsleep, iso, ret, sleepAck, busy};
      testsRun++;
      if (obs !== 8'b1111_0000) begin
        testsFailed++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", m, obs, 8'b1111_0000);
      end
    end
  endtask

  task automatic test_power_down();
    logic [7:0] obs;
    logic [7:0] expv;
    sleepReq = 1'b1;
    for (int m = 1; m <= 9; m++) begin
      @(negedge clk);
      obs  = {nsleep, iso, ret, sleepAck, busy};
      expv = expectDown(m);
      testsRun++;
      if (obs !== expv) begin
        testsFailed++;
        $display("[TB] FAIL power_down T+%0d: got %b expected %b", m, obs, expv);
      end
    end
  endtask

  task automatic test_power_up();
    logic [7:0] obs;
    logic [7:0] expv;
    sleepReq = 1'b0;
    for (int m = 1; m <= 37; m++) begin
      @(negedge clk);
      obs  = {nsleep, iso, ret, sleepAck, busy};
      expv = expectUp(m);
      testsRun++;
      if (obs !== expv) begin
        testsFailed++;
        $display("[TB] FAIL power_up T+%0d: got %b expected %b", m, obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs;
    logic [7:0] expv;
    sleepReq = 1'b1;
    for (int m = 1; m <= 8; m++) begin
      @(negedge clk);
      obs  = {nsleep, iso, ret, sleepAck, busy};
      expv = (m <= 7) ? expectDown(m) : expectUp(m - 7);
      testsRun++;
      if (obs !== expv) begin
        testsFailed++;
        $display("[TB] FAIL back_to_back T+%0d: got %b expected %b", m, obs, expv);
      end
      if (m == 3) sleepReq = 1'b0;
    end
  endtask

  task automatic test_reset_mid_wake();
    logic [7:0] obs;
    logic [7:0] expv;
    for (int m = 9; m <= 19; m++) begin
      @(negedge clk);
      obs  = {nsleep, iso, ret, sleepAck, busy};
      expv = expectUp(m - 7);
      testsRun++;
      if (obs !== expv) begin
        testsFailed++;
        $display("[TB] FAIL mid_wake T+%0d: got %b expected %b", m, obs, expv);
      end
    end
    #2 nreset = 1'b0;
    #1;
    obs = {nsleep, iso, ret, sleepAck, busy};
    testsRun++;
    if (obs !== 8'b1111_0000) begin
      testsFailed++;
      $display("[TB] FAIL mid_wake_async_reset: got %b expected %b", obs, 8'b1111_0000);
    end
    #1 nreset = 1'b1;
    @(negedge clk);
    obs = {nsleep, iso, ret, sleepAck, busy};
    testsRun++;
    if (obs !== 8'b1111_0000) begin
      testsFailed++;
      $display("[TB] FAIL mid_wake_after_reset: got %b expected %b", obs, 8'b1111_0000);
    end
  endtask

  task automatic test_req_held_from_reset();
    logic [7:0] obs;
    logic [7:0] expv;
    nreset   = 1'b0;
    sleepReq = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    for (int m = 1; m <= 7; m++) begin
      @(negedge clk);
      obs  = {nsleep, iso, ret, sleepAck, busy};
      expv = expectDown(m);
      testsRun++;
      if (obs !== expv) begin
        testsFailed++;
        $display("[TB] FAIL held_req T+%0d: got %b expected %b", m, obs, expv);
      end
    end
    sleepReq = 1'b0;
    repeat (36) @(negedge clk);
    obs = {nsleep, iso, ret, sleepAck, busy};
    testsRun++;
    if (obs !== 8'b1111_0000) begin
      testsFailed++;
      $display("[TB] FAIL held_req_wake: got %b expected %b", obs, 8'b1111_0000);
    end
  endtask

  task automatic test_invariants();
    logic bad1;
    logic bad8;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) req1 = ~req1;
      if ($urandom_range(0, 7) == 0) req8 = ~req8;
      @(negedge clk);
      bad1 = ((ns1 != 1'b1) && !iso1) || ((ns1 == 1'b0) && !ret1) ||
             (ack1 && (ns1 != 1'b0 || busy1));
      bad8 = ((ns8 != 8'hFF) && !iso8) || ((ns8 == 8'h00) && !ret8) ||
             (ack8 && (ns8 != 8'h00 || busy8));
      testsRun++;
      if (bad1) begin
        testsFailed++;
        $display("[TB] FAIL invariant_n1 cycle %0d: got ns=%b iso=%b ret=%b ack=%b required consistent",
                 c, ns1, iso1, ret1, ack1);
      end
      testsRun++;
      if (bad8) begin
        testsFailed++;
        $display("[TB] FAIL invariant_n8 cycle %0d: got ns=%b iso=%b ret=%b ack=%b required consistent",
                 c, ns8, iso8, ret8, ack8);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    nreset      = 1'b0;
    sleepReq    = 1'b0;
    req1        = 1'b0;
    req8        = 1'b0;
    test_reset();
    test_power_down();
    test_power_up();
    test_back_to_back();
    test_reset_mid_wake();
    test_req_held_from_reset();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
